fx_mul_rr_arbiter: RTL and testbench

//  Shares one pipelined fixed-point multiplier among NREQ requesters (LSM regression / path units).

---
 rtl/fx_mul_rr_arbiter.sv | 152 +++++++++++++++
 tb/tb_fx_mul_rr_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fx_mul_rr_arbiter.sv
// fx_mul_rr_arbiter
// Round-robin front end for one shared, pipelined fixed-point multiplier.
// Each cycle one valid requester is granted and its operands are issued.
// A tag pipeline tracks which requester owns each in-flight product.
// When the product returns, it is routed back to that requester as a one-hot pulse.
module fx_mul_rr_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic                    mul_valid_in,
    output logic [WIDTH-1:0]        mul_a,
    output logic [WIDTH-1:0]        mul_b,
    input  logic                    mul_valid_out,
    input  logic [WIDTH-1:0]        mul_result,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [WIDTH-1:0]        rsp_data,
    output logic                    busy,
    output logic                    tag_err
);

    localparam int IDW  = $clog2(NREQ);
    localparam int CNTW = $clog2(MUL_LAT + 2);

    logic [IDW-1:0]   r_rr_ptr;
    logic [MUL_LAT-1:0] r_tag_v;
    logic [IDW-1:0]   r_tag_id [MUL_LAT];
    logic [NREQ-1:0]  r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_tag_err;
    logic [CNTW-1:0]  r_out_cnt;

    logic [NREQ-1:0]  w_grant_raw;
    logic [IDW-1:0]   w_grant_id;
    logic             w_issue_raw;
    logic [NREQ-1:0]  w_grant;
    logic [WIDTH-1:0] w_mul_a;
    logic [WIDTH-1:0] w_mul_b;
    logic             w_tail_v;
    logic [IDW-1:0]   w_tail_id;
    logic             w_rsp_any;

    // Round-robin scan starting at r_rr_ptr; the first valid requester wins.
    always_comb begin
        int idx;
        idx         = 0;
        w_grant_raw = '0;
        w_grant_id  = '0;
        w_issue_raw = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(r_rr_ptr) + k) % NREQ;
            if (!w_issue_raw && req_valid[idx]) begin
                w_grant_raw[idx] = 1'b1;
                w_grant_id       = IDW'(idx);
                w_issue_raw      = 1'b1;
            end
        end
    end

    // Outward grant/issue is suppressed while reset is held; internal state
    // is held in reset anyway, so the ungated grant is used for the flops.
    assign w_grant      = w_grant_raw & {NREQ{rst_n}};
    assign req_ready    = w_grant;
    assign mul_valid_in = w_issue_raw & rst_n;

    // Operand mux: AND-OR of the granted requester's operands, zero when idle.
    always_comb begin
        w_mul_a = '0;
        w_mul_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_mul_a = w_mul_a | (req_a[i*WIDTH +: WIDTH] & {WIDTH{w_grant[i]}});
            w_mul_b = w_mul_b | (req_b[i*WIDTH +: WIDTH] & {WIDTH{w_grant[i]}});
        end
    end

    assign mul_a = w_mul_a;
    assign mul_b = w_mul_b;

    // Pointer moves to the slot just after the winner so it has lowest priority next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_issue_raw) begin
            r_rr_ptr <= (w_grant_id == IDW'(NREQ - 1)) ? '0 : w_grant_id + IDW'(1);
        end
    end

    // Tag shift register; its last stage is aligned with mul_valid_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_v <= '0;
            for (int k = 0; k < MUL_LAT; k++) begin
                r_tag_id[k] <= '0;
            end
        end else begin
            r_tag_v[0]  <= w_issue_raw;
            r_tag_id[0] <= w_grant_id;
            for (int k = 1; k < MUL_LAT; k++) begin
                r_tag_v[k]  <= r_tag_v[k-1];
                r_tag_id[k] <= r_tag_id[k-1];
            end
        end
    end

    assign w_tail_v  = r_tag_v[MUL_LAT-1];
    assign w_tail_id = r_tag_id[MUL_LAT-1];

    // Route a returning product to its owner; any valid/tag disagreement is sticky.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_tag_err   <= 1'b0;
        end else begin
            r_rsp_valid <= '0;
            if (mul_valid_out && w_tail_v) begin
                r_rsp_valid <= {{(NREQ-1){1'b0}}, 1'b1} << w_tail_id;
                r_rsp_data  <= mul_result;
            end
            if (mul_valid_out != w_tail_v) begin
                r_tag_err <= 1'b1;
            end
        end
    end

    assign w_rsp_any = |r_rsp_valid;

    // Outstanding ops: counted from issue until the response pulse is seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_cnt <= '0;
        end else begin
            case ({w_issue_raw, w_rsp_any})
                2'b10:   r_out_cnt <= r_out_cnt + CNTW'(1);
                2'b01:   r_out_cnt <= r_out_cnt - CNTW'(1);
                default: r_out_cnt <= r_out_cnt;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign tag_err   = r_tag_err;
    assign busy      = (r_out_cnt != '0);

endmodule

// File: tb/tb_fx_mul_rr_arbiter.sv
// Directed bench for fx_mul_rr_arbiter with a behavioural Q16.16 multiplier.
module tb_fx_mul_rr_arbiter;

    localparam int NREQ    = 4;
    localparam int WIDTH   = 32;
    localparam int MUL_LAT = 3;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  mul_valid_in;
    logic [WIDTH-1:0]      mul_a;
    logic [WIDTH-1:0]      mul_b;
    logic                  mul_valid_out;
    logic [WIDTH-1:0]      mul_result;
    logic [NREQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]      rsp_data;
    logic                  busy;
    logic                  tag_err;
    logic                  inject;

    int n_checks;
    int n_pass;

    fx_mul_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .mul_valid_in (mul_valid_in),
        .mul_a        (mul_a),
        .mul_b        (mul_b),
        .mul_valid_out(mul_valid_out),
        .mul_result   (mul_result),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .busy         (busy),
        .tag_err      (tag_err)
    );

    always #5 clk = ~clk;

    // Shared multiplier model: Q16.16 signed product, MUL_LAT-deep pipeline.
    logic             m_v [MUL_LAT];
    logic [WIDTH-1:0] m_r [MUL_LAT];
    logic signed [63:0] m_prod;

    assign m_prod = $signed({{32{mul_a[31]}}, mul_a}) * $signed({{32{mul_b[31]}}, mul_b});

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < MUL_LAT; k++) begin
                m_v[k] <= 1'b0;
                m_r[k] <= '0;
            end
        end else begin
            m_v[0] <= mul_valid_in;
            m_r[0] <= m_prod[47:16];
            for (int k = 1; k < MUL_LAT; k++) begin
                m_v[k] <= m_v[k-1];
                m_r[k] <= m_r[k-1];
            end
        end
    end

    assign mul_valid_out = m_v[MUL_LAT-1] | inject;
    assign mul_result    = m_r[MUL_LAT-1];

    // One line per delivered response.
    always @(negedge clk) begin
        if (rst_n && rsp_valid != '0)
            $display("rsp: valid=%b data=%h", rsp_valid, rsp_data);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        inject    = 1'b0;
        req_valid = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        clk       = 1'b0;
        rst_n     = 1'b0;
        inject    = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;

        // Reset state
        #2;
        chk("rst_ready",   64'(req_ready),    64'h0);
        chk("rst_mvin",    64'(mul_valid_in), 64'h0);
        chk("rst_rsp",     64'(rsp_valid),    64'h0);
        chk("rst_data",    64'(rsp_data),     64'h0);
        chk("rst_busy",    64'(busy),         64'h0);
        chk("rst_tagerr",  64'(tag_err),      64'h0);
        tick();
        tick();
        rst_n = 1'b1;

        // 1. Single request from requester 2: 2.0 * 3.0 = 6.0
        tick();
        req_valid = 4'b0100;
        req_a[2*WIDTH +: WIDTH] = 32'h0002_0000;
        req_b[2*WIDTH +: WIDTH] = 32'h0003_0000;
        #1;
        chk("t1_ready", 64'(req_ready),    64'h4);
        chk("t1_mvin",  64'(mul_valid_in), 64'h1);
        chk("t1_mula",  64'(mul_a),        64'h0002_0000);
        chk("t1_mulb",  64'(mul_b),        64'h0003_0000);
        for (int c = 1; c <= 5; c++) begin
            tick();
            req_valid = '0;
            #1;
            if (c == 1) begin
                chk("t1_busy_inflight", 64'(busy),  64'h1);
                chk("t1_idle_mula",     64'(mul_a), 64'h0);
                chk("t1_idle_ready",    64'(req_ready), 64'h0);
            end
            if (c < 4) chk("t1_rsp_early", 64'(rsp_valid), 64'h0);
            if (c == 4) begin
                chk("t1_rsp",  64'(rsp_valid), 64'h4);
                chk("t1_data", 64'(rsp_data),  64'h0006_0000);
            end
            if (c == 5) begin
                chk("t1_rsp_end",  64'(rsp_valid), 64'h0);
                chk("t1_busy_end", 64'(busy),      64'h0);
                chk("t1_data_hold", 64'(rsp_data), 64'h0006_0000);
            end
        end

        // 2 + 4. All valid for 8 cycles: rotating grants, back-to-back issue
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = 32'(i) << 16;
            req_b[i*WIDTH +: WIDTH] = 32'h0001_0000;
        end
        for (int c = 0; c <= 12; c++) begin
            tick();
            req_valid = (c < 8) ? 4'hF : 4'h0;
            #1;
            if (c < 8) begin
                chk("t2_ready", 64'(req_ready),    64'(1) << (c % 4));
                chk("t2_mvin",  64'(mul_valid_in), 64'h1);
                chk("t2_mula",  64'(mul_a),        64'(c % 4) << 16);
            end
            if (c >= 4 && c < 12) begin
                chk("t2_rsp",  64'(rsp_valid), 64'(1) << ((c - 4) % 4));
                chk("t2_data", 64'(rsp_data),  64'((c - 4) % 4) << 16);
            end else begin
                chk("t2_rsp_idle", 64'(rsp_valid), 64'h0);
            end
            if (c >= 1 && c <= 11) chk("t2_busy", 64'(busy), 64'h1);
            if (c == 6) chk("t2_cnt_peak", 64'(dut.r_out_cnt), 64'(MUL_LAT + 1));
            if (c == 12) chk("t2_busy_end", 64'(busy), 64'h0);
        end

        // 3. req_valid=1001 from rr_ptr=1: grants alternate 3,0
        do_reset();
        tick();
        req_valid = 4'b0001;
        #1;
        chk("t3_prime", 64'(req_ready), 64'h1);
        for (int c = 0; c < 6; c++) begin
            tick();
            req_valid = 4'b1001;
            #1;
            chk("t3_ready", 64'(req_ready), (c % 2 == 0) ? 64'h8 : 64'h1);
        end
        tick();
        req_valid = '0;

        // 5. Spurious result with empty pipeline -> sticky tag_err, no response
        do_reset();
        tick();
        tick();
        tick();
        inject = 1'b1;
        #1;
        chk("t5_err_before", 64'(tag_err), 64'h0);
        tick();
        inject = 1'b0;
        #1;
        chk("t5_err_set", 64'(tag_err),   64'h1);
        chk("t5_no_rsp",  64'(rsp_valid), 64'h0);
        tick();
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        tick();
        tick();
        tick();
        #1;
        chk("t5_rsp_after_err", 64'(rsp_valid), 64'h1);
        chk("t5_err_sticky",    64'(tag_err),   64'h1);

        // 6. Reset with two ops in flight
        do_reset();
        #1;
        chk("t6_err_cleared", 64'(tag_err), 64'h0);
        tick();
        req_valid = 4'b0110;
        #1;
        chk("t6_g1", 64'(req_ready), 64'h2);
        tick();
        #1;
        chk("t6_g2", 64'(req_ready), 64'h4);
        tick();
        rst_n = 1'b0;
        #1;
        chk("t6_ready", 64'(req_ready),    64'h0);
        chk("t6_mvin",  64'(mul_valid_in), 64'h0);
        chk("t6_mula",  64'(mul_a),        64'h0);
        chk("t6_busy",  64'(busy),         64'h0);
        chk("t6_rsp",   64'(rsp_valid),    64'h0);
        chk("t6_data",  64'(rsp_data),     64'h0);
        tick();
        rst_n     = 1'b1;
        req_valid = '0;
        for (int c = 0; c < 6; c++) begin
            tick();
            #1;
            chk("t6_no_rsp", 64'(rsp_valid), 64'h0);
            chk("t6_no_err", 64'(tag_err),   64'h0);
        end
        tick();
        req_valid = 4'b1010;
        #1;
        chk("t6_lowest", 64'(req_ready), 64'h2);
        tick();
        req_valid = '0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
